// File: rtl/time_set_controller.sv
// time_set_controller: debounced MODE/INC front panel driving the time/alarm edit FSM and load strobes
module time_set_debounce #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(CYCLES + 1);
  logic s1_q, s2_q, prev_q, press_q;
  logic lvl_q, lvl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (s2_q != lvl_q) begin
      if (cnt_q == CW'(CYCLES - 1)) lvl_d = s2_q;
      else cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      prev_q  <= lvl_q;
      press_q <= lvl_q & ~prev_q;
    end
  end
  assign level = lvl_q;
  assign press = press_q;
endmodule

module time_set_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter int TIMEOUT_CYCLES  = 500000000,
  parameter int BLINK_CYCLES    = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [6:0] cur_minutes,
  input  logic [5:0] cur_hours,
  output logic [6:0] set_minutes,
  output logic [5:0] set_hours,
  output logic       load_time,
  output logic       load_alarm,
  output logic       edit_active,
  output logic [1:0] edit_field,
  output logic       edit_alarm,
  output logic       blink
);
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(BLINK_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, T_HOURS, T_MIN, A_HOURS, A_MIN} state_t;
  state_t state_q, state_d;

  logic mode_lvl, mode_press, inc_lvl, inc_press;
  logic rep_fire, inc, to_fire, in_alarm, edit_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic blink_q, blink_d, load_time_q, load_time_d, load_alarm_q, load_alarm_d;
  logic [5:0] th_q, th_d, ah_q, ah_d, eh_q, eh_d;
  logic [6:0] tm_q, tm_d, am_q, am_d, em_q, em_d;

  time_set_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clk(clk), .rst(rst), .raw(btn_mode), .level(mode_lvl), .press(mode_press)
  );
  time_set_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clk(clk), .rst(rst), .raw(btn_inc), .level(inc_lvl), .press(inc_press)
  );

  // rep_cnt_q holds cycles since the INC press; 0 means no repeat pending
  always_comb begin
    rep_fire  = inc_lvl && rep_cnt_q == RW'(REPEAT_DELAY);
    rep_cnt_d = !inc_lvl ? '0 :
                inc_press ? RW'(1) :
                rep_fire ? RW'(REPEAT_DELAY - REPEAT_RATE + 1) :
                rep_cnt_q != '0 ? rep_cnt_q + 1'b1 : '0;
    inc       = (inc_press | rep_fire) & ~mode_press;
    in_alarm  = state_q == A_HOURS || state_q == A_MIN;
    to_fire   = state_q != IDLE && !mode_press && !inc_press && !rep_fire &&
                to_cnt_q == TW'(TIMEOUT_CYCLES - 1);
    to_cnt_d  = (state_q == IDLE || mode_press || inc_press || rep_fire || to_fire) ? '0 : to_cnt_q + 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    th_d         = th_q;
    tm_d         = tm_q;
    ah_d         = ah_q;
    am_d         = am_q;
    eh_d         = eh_q;
    em_d         = em_q;
    load_time_d  = 1'b0;
    load_alarm_d = 1'b0;
    if (to_fire) begin
      state_d = IDLE;
      if (in_alarm) begin
        ah_d = eh_q;
        am_d = em_q;
      end
    end else if (mode_press) begin
      case (state_q)
        IDLE: begin
          state_d = T_HOURS;
          th_d    = cur_hours;
          tm_d    = cur_minutes;
        end
        T_HOURS: state_d = T_MIN;
        T_MIN: begin
          state_d     = A_HOURS;
          load_time_d = 1'b1;
          eh_d        = ah_q;
          em_d        = am_q;
        end
        A_HOURS: state_d = A_MIN;
        A_MIN: begin
          state_d      = IDLE;
          load_alarm_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (inc) begin
      case (state_q)
        T_HOURS: th_d = th_q >= 6'd23 ? 6'd0 : th_q + 1'b1;
        T_MIN:   tm_d = tm_q >= 7'd59 ? 7'd0 : tm_q + 1'b1;
        A_HOURS: ah_d = ah_q >= 6'd23 ? 6'd0 : ah_q + 1'b1;
        A_MIN:   am_d = am_q >= 7'd59 ? 7'd0 : am_q + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    edit_d      = state_d != IDLE;
    blink_cnt_d = (!edit_d || state_d != state_q || blink_cnt_q == BW'(BLINK_CYCLES - 1)) ? '0 : blink_cnt_q + 1'b1;
    blink_d     = (!edit_d || state_d != state_q) ? 1'b0 :
                  blink_cnt_q == BW'(BLINK_CYCLES - 1) ? ~blink_q : blink_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      rep_cnt_q    <= '0;
      to_cnt_q     <= '0;
      blink_cnt_q  <= '0;
      blink_q      <= 1'b0;
      load_time_q  <= 1'b0;
      load_alarm_q <= 1'b0;
      th_q         <= '0;
      tm_q         <= '0;
      ah_q         <= '0;
      am_q         <= '0;
      eh_q         <= '0;
      em_q         <= '0;
    end else begin
      state_q      <= state_d;
      rep_cnt_q    <= rep_cnt_d;
      to_cnt_q     <= to_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_q      <= blink_d;
      load_time_q  <= load_time_d;
      load_alarm_q <= load_alarm_d;
      th_q         <= th_d;
      tm_q         <= tm_d;
      ah_q         <= ah_d;
      am_q         <= am_d;
      eh_q         <= eh_d;
      em_q         <= em_d;
    end
  end

  // during a strobe the outputs carry the group being loaded, not the current state's group
  logic show_alarm;
  assign show_alarm  = (in_alarm && !load_time_q) || load_alarm_q;
  assign set_hours   = show_alarm ? ah_q : th_q;
  assign set_minutes = show_alarm ? am_q : tm_q;
  assign load_time   = load_time_q;
  assign load_alarm  = load_alarm_q;
  assign edit_active = state_q != IDLE;
  assign edit_alarm  = in_alarm;
  assign edit_field  = (state_q == T_HOURS || state_q == A_HOURS) ? 2'd1 :
                       (state_q == T_MIN || state_q == A_MIN) ? 2'd2 : 2'd0;
  assign blink       = blink_q;
endmodule

// File: tb/tb_time_set_controller.sv
// tb_time_set_controller: directed front-panel sequences with a strobe scoreboard
module tb_time_set_controller;
  logic clk = 1'b0, rst = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
  logic [6:0] cur_minutes = 7'd58;
  logic [5:0] cur_hours = 6'd22;
  logic [6:0] set_minutes;
  logic [5:0] set_hours;
  logic load_time, load_alarm, edit_active, edit_alarm, blink;
  logic [1:0] edit_field;

  int checks = 0, failures = 0;
  typedef struct {logic alarm; logic [5:0] h; logic [6:0] m;} exp_t;
  exp_t sb[$];
  exp_t e;
  logic prev_strobe = 1'b0;

  always #5 clk = ~clk;

  time_set_controller #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(5), .TIMEOUT_CYCLES(300), .BLINK_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_minutes(cur_minutes), .cur_hours(cur_hours),
    .set_minutes(set_minutes), .set_hours(set_hours),
    .load_time(load_time), .load_alarm(load_alarm),
    .edit_active(edit_active), .edit_field(edit_field), .edit_alarm(edit_alarm), .blink(blink)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic m, input logic i);
    btn_mode = m;
    btn_inc = i;
    tick(10);
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    tick(10);
  endtask

  task automatic expect_load(input logic a, input logic [5:0] h, input logic [6:0] m);
    sb.push_back('{alarm: a, h: h, m: m});
  endtask

  always @(negedge clk) begin
    if (load_time || load_alarm) begin
      chk("strobe_exclusive", load_time & load_alarm, 0);
      chk("strobe_gap", prev_strobe, 0);
      chk("strobe_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("strobe_kind", load_alarm, e.alarm);
        chk("strobe_hours", set_hours, e.h);
        chk("strobe_minutes", set_minutes, e.m);
      end
    end
    prev_strobe <= load_time | load_alarm;
  end

  initial begin
    tick(3);
    chk("rst_set", {set_hours, set_minutes}, 0);
    chk("rst_strobes", {load_time, load_alarm}, 0);
    chk("rst_edit", {edit_active, edit_field, edit_alarm}, 0);
    chk("rst_blink", blink, 0);
    rst = 1'b1;
    tick(2);

    for (int i = 0; i < 10; i++) begin
      btn_mode = ~btn_mode;
      tick(2);
    end
    chk("bounce_ignored", edit_active, 0);
    btn_mode = 1'b1;
    tick(7);
    chk("bounce_latency_early", edit_field, 0);
    tick(1);
    chk("bounce_latency", edit_field, 1);
    chk("capture_hours", set_hours, 22);
    chk("capture_minutes", set_minutes, 58);
    chk("blink_entry", blink, 0);
    tick(7);
    chk("blink_low", blink, 0);
    tick(1);
    chk("blink_toggle", blink, 1);
    tick(30);
    chk("bounce_single", edit_field, 1);
    btn_mode = 1'b0;
    tick(10);

    press(0, 1);
    press(0, 1);
    chk("hour_wrap", set_hours, 0);
    press(1, 0);
    chk("field_minutes", edit_field, 2);
    for (int i = 0; i < 3; i++) press(0, 1);
    chk("minute_wrap", set_minutes, 1);
    chk("minute_no_carry", set_hours, 0);
    expect_load(1'b0, 6'd0, 7'd1);
    press(1, 0);
    chk("alarm_group", edit_alarm, 1);
    chk("alarm_field", edit_field, 1);
    chk("alarm_shadow_min", set_minutes, 0);

    press(1, 0);
    chk("alarm_min_field", edit_field, 2);
    for (int i = 0; i < 57; i++) press(0, 1);
    chk("alarm_min_57", set_minutes, 57);
    btn_inc = 1'b1;
    tick(8);
    chk("rep_press", set_minutes, 58);
    tick(19);
    chk("rep_before", set_minutes, 58);
    tick(1);
    chk("rep_first", set_minutes, 59);
    tick(5);
    chk("rep_second", set_minutes, 0);
    tick(1);
    btn_inc = 1'b0;
    tick(4);
    chk("rep_third", set_minutes, 1);
    tick(20);
    chk("rep_stop", set_minutes, 1);

    expect_load(1'b1, 6'd0, 7'd1);
    press(1, 0);
    chk("commit_idle", edit_active, 0);
    chk("idle_time_shadow", {set_hours, set_minutes}, {6'd0, 7'd1});
    press(1, 0);
    press(1, 0);
    expect_load(1'b0, 6'd22, 7'd58);
    press(1, 0);
    chk("alarm_retained", {set_hours, set_minutes}, {6'd0, 7'd1});
    for (int i = 0; i < 7; i++) press(0, 1);
    press(1, 0);
    for (int i = 0; i < 29; i++) press(0, 1);
    chk("alarm_edit", {set_hours, set_minutes}, {6'd7, 7'd30});
    expect_load(1'b1, 6'd7, 7'd30);
    press(1, 0);
    chk("alarm_commit_idle", edit_active, 0);
    press(1, 0);
    press(1, 0);
    expect_load(1'b0, 6'd22, 7'd58);
    press(1, 0);
    chk("alarm_reenter", {set_hours, set_minutes}, {6'd7, 7'd30});
    press(0, 1);
    chk("alarm_inc_hours", set_hours, 8);
    tick(250);
    chk("timeout_early", edit_active, 1);
    tick(70);
    chk("timeout_idle", edit_active, 0);
    chk("timeout_field", edit_field, 0);
    press(1, 0);
    press(1, 0);
    expect_load(1'b0, 6'd22, 7'd58);
    press(1, 0);
    chk("abort_restore", {set_hours, set_minutes}, {6'd7, 7'd30});

    press(1, 0);
    expect_load(1'b1, 6'd7, 7'd30);
    press(1, 0);
    press(1, 0);
    chk("simul_setup", edit_field, 1);
    press(1, 1);
    chk("simul_field", edit_field, 2);
    chk("simul_hours", set_hours, 22);
    chk("simul_minutes", set_minutes, 58);

    tick(3);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_set", {set_hours, set_minutes}, 0);
    chk("mid_rst_edit", {edit_active, edit_field, edit_alarm, blink}, 0);
    chk("mid_rst_strobe", {load_time, load_alarm}, 0);
    tick(2);
    rst = 1'b1;
    tick(20);
    chk("post_rst_idle", {edit_active, edit_field}, 0);
    chk("post_rst_shadow", {set_hours, set_minutes}, 0);
    press(1, 0);
    chk("post_rst_edit", edit_field, 1);
    chk("post_rst_capture", {set_hours, set_minutes}, {6'd22, 7'd58});

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
